// File: rtl/nearest_search_ctrl.sv
// nearest_search_ctrl: streams a burst of samples through one |x - reff| compare
// stage and keeps the sample closest to the latched reference.
module nearest_search_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] reff_in,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [WIDTH-1:0] best,
    output logic [CNT_W-1:0] best_idx,
    output logic [WIDTH-1:0] best_dist
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reff_q, reff_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [CNT_W-1:0] best_idx_q, best_idx_d;
    logic [WIDTH-1:0] best_dist_q, best_dist_d;

    logic [CNT_W-1:0] len_sat_c;
    logic [WIDTH-1:0] dist_c;
    logic             xfer_c;
    logic             last_c;

    // Burst length clamp, absolute distance and transfer qualifiers
    always_comb begin
        len_sat_c = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;
        dist_c    = (in_data >= reff_q) ? (in_data - reff_q) : (reff_q - in_data);
        xfer_c    = (state_q == RUN) && in_valid;
        last_c    = (cnt_q == (len_q - CNT_W'(1)));
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reff_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            empty_q     <= 1'b0;
            best_q      <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
        end else begin
            state_q     <= state_d;
            reff_q      <= reff_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            empty_q     <= empty_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            best_dist_q <= best_dist_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_sat_c == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (xfer_c && last_c) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags follow the upcoming state; datapath loads on start and on transfers
    always_comb begin
        reff_d      = reff_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        empty_d     = empty_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        best_dist_d = best_dist_q;
        in_ready_d  = (state_d == RUN);
        busy_d      = (state_d == RUN);
        done_d      = (state_d == FIN);

        if ((state_q == IDLE) && start) begin
            reff_d  = reff_in;
            len_d   = len_sat_c;
            cnt_d   = '0;
            empty_d = 1'b0;
            if (len_sat_c == '0) begin
                empty_d     = 1'b1;
                best_d      = '0;
                best_idx_d  = '0;
                best_dist_d = '0;
            end
        end else if (xfer_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            // Strict less-than keeps the earliest sample on ties
            if ((cnt_q == '0) || (dist_c < best_dist_q)) begin
                best_d      = in_data;
                best_idx_d  = cnt_q;
                best_dist_d = dist_c;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign empty     = empty_q;
    assign best      = best_q;
    assign best_idx  = best_idx_q;
    assign best_dist = best_dist_q;

endmodule

// File: tb/tb_nearest_search_ctrl.sv
// Self-checking bench for nearest_search_ctrl: directed bursts, a cycle-level
// behavioural model checked every cycle, and literal result checks per burst.
module tb_nearest_search_ctrl;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] reff_in = '0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, busy, done, empty;
    logic [WIDTH-1:0] best, best_dist;
    logic [CNT_W-1:0] best_idx;

    nearest_search_ctrl #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reff_in(reff_in), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .done(done), .empty(empty), .best(best), .best_idx(best_idx), .best_dist(best_dist)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    logic [WIDTH-1:0] smp [0:31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what each output must be after the most recent edge
    bit             m_run = 1'b0;
    bit             m_fin = 1'b0;
    bit             m_empty = 1'b0;
    int             m_len = 0;
    int             m_cnt = 0;
    int             m_idx = 0;
    logic [WIDTH-1:0] m_ref = '0;
    logic [WIDTH-1:0] m_best = '0;
    logic [WIDTH-1:0] m_dist = '0;

    // Compare DUT against the model every cycle, then advance the model to the next edge
    always @(negedge clk) begin
        logic [WIDTH-1:0] d;
        bit nf;
        if (mon_on) begin
            chk("busy", busy, m_run);
            chk("in_ready", in_ready, m_run);
            chk("done", done, m_fin);
            chk("empty", empty, m_empty);
            if (!m_run) begin
                chk("best", best, m_best);
                chk("best_idx", best_idx, m_idx);
                chk("best_dist", best_dist, m_dist);
            end
        end
        nf = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0; m_fin = 1'b0; m_empty = 1'b0;
            m_best = '0; m_idx = 0; m_dist = '0; m_cnt = 0;
        end else begin
            if (m_run && in_valid) begin
                d = (in_data > m_ref) ? in_data - m_ref : m_ref - in_data;
                if (m_cnt == 0 || d < m_dist) begin
                    m_best = in_data; m_dist = d; m_idx = m_cnt;
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_run = 1'b0;
                    nf = 1'b1;
                end
            end else if (!m_run && !m_fin && start) begin
                m_ref   = reff_in;
                m_len   = (len > MAX_LEN) ? MAX_LEN : int'(len);
                m_cnt   = 0;
                m_empty = (m_len == 0);
                if (m_len == 0) begin
                    nf = 1'b1;
                    m_best = '0; m_idx = 0; m_dist = '0;
                end else begin
                    m_run = 1'b1;
                end
            end
            m_fin = nf;
        end
    end

    // One burst: n samples from smp[], valid pattern vp per RUN cycle, optional mid-run
    // start pulse at cycle start_at, optional reset after rst_after transfers.
    task automatic burst(input logic [WIDTH-1:0] r, input logic [CNT_W-1:0] l, input int n,
                         input logic [31:0] vp, input int start_at, input int rst_after);
        int si;
        int cyc;
        bit x;
        start = 1'b1; reff_in = r; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        si = 0; cyc = 0;
        while (si < n && cyc < 100) begin
            if (rst_after >= 0 && si == rst_after) begin
                in_valid = 1'b0; rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            in_valid = (cyc < 32) ? vp[cyc] : 1'b1;
            in_data  = in_valid ? smp[si] : r;
            start    = (cyc == start_at);
            x = in_valid && in_ready;
            @(posedge clk); #1;
            if (x) si++;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        chk("samples_fed", si, n);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("done_latency", cyc, 0);
    endtask

    task automatic lit(input int b, input int i, input int d, input int e);
        chk("lit_best", best, b);
        chk("lit_idx", best_idx, i);
        chk("lit_dist", best_dist, d);
        chk("lit_empty", empty, e);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
        lit(0, 0, 0, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);

        // Basic burst
        smp[0] = 8'd90; smp[1] = 8'd105; smp[2] = 8'd97; smp[3] = 8'd130;
        burst(8'd100, 5'd4, 4, 32'hFFFF_FFFF, -1, -1);
        lit(97, 2, 3, 0);
        next_cycle();
        lit(97, 2, 3, 0);

        // Tie keeps earlier sample
        smp[0] = 8'd45; smp[1] = 8'd55; smp[2] = 8'd60;
        burst(8'd50, 5'd3, 3, 32'hFFFF_FFFF, -1, -1);
        lit(45, 0, 5, 0);
        next_cycle();

        // Extremes
        smp[0] = 8'd255; smp[1] = 8'd0;
        burst(8'd0, 5'd2, 2, 32'hFFFF_FFFF, -1, -1);
        lit(0, 1, 0, 0);
        next_cycle();
        smp[0] = 8'd0; smp[1] = 8'd1;
        burst(8'd255, 5'd2, 2, 32'hFFFF_FFFF, -1, -1);
        lit(1, 1, 254, 0);
        next_cycle();

        // Stalls: valid 1,0,0,1,0,1; idle data equals reff and must not be taken
        smp[0] = 8'd20; smp[1] = 8'd12; smp[2] = 8'd9;
        burst(8'd10, 5'd3, 3, 32'h0000_0029, -1, -1);
        lit(9, 2, 1, 0);
        next_cycle();

        // Empty burst
        burst(8'd77, 5'd0, 0, 32'hFFFF_FFFF, -1, -1);
        lit(0, 0, 0, 1);
        next_cycle();
        lit(0, 0, 0, 1);

        // Length saturation: 31 -> 16 transfers
        for (int i = 0; i < 32; i++) smp[i] = 8'(200 - 3 * i);
        burst(8'd150, 5'd31, 16, 32'hFFFF_FFFF, -1, -1);
        lit(155, 15, 5, 0);
        next_cycle();

        // start pulsed during RUN is ignored
        smp[0] = 8'd30; smp[1] = 8'd25; smp[2] = 8'd18;
        burst(8'd20, 5'd3, 3, 32'hFFFF_FFFF, 1, -1);
        lit(18, 2, 2, 0);
        next_cycle();

        // Reset after 2 of 5 samples
        smp[0] = 8'd1; smp[1] = 8'd2; smp[2] = 8'd3; smp[3] = 8'd4; smp[4] = 8'd5;
        burst(8'd100, 5'd5, 5, 32'hFFFF_FFFF, -1, 2);
        lit(0, 0, 0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_done", done, 0);
        repeat (3) next_cycle();
        chk("abort_no_done", done, 0);

        // Fresh burst after reset
        smp[0] = 8'd3; smp[1] = 8'd9;
        burst(8'd7, 5'd2, 2, 32'hFFFF_FFFF, -1, -1);
        lit(9, 1, 2, 0);
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nearest_search_ctrl.md
Name: nearest_search_ctrl

Overview:
- Sequential controller around one absolute-distance compare stage (|x - reff|, pick smaller).
- Streams a burst of samples through that stage one per cycle and tracks the sample closest to a latched reference.
- Reports the closest value, its index and its distance.
- Sits between a sample source with a valid/ready handshake and downstream logic that consumes the single-cycle done pulse.

Parameters:
- WIDTH, 8, bit width of reference, samples and distance.
- MAX_LEN, 16, maximum samples per burst.
- CNT_W, 5, width of len and of the sample counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- reff_in  input  WIDTH  reference value; latched on accepted start.
- len  input  CNT_W  burst length; latched on accepted start. Values above MAX_LEN saturate to MAX_LEN.
- in_valid  input  1  sample present on in_data.
- in_data  input  WIDTH  sample value (unsigned).
- in_ready  output  1  controller accepts a sample this cycle.
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted (exclusive).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- empty  output  1  last burst had len = 0; result outputs are 0.
- best  output  WIDTH  closest sample of the last burst.
- best_idx  output  CNT_W  0-based index of best within the burst.
- best_dist  output  WIDTH  |best - reff|.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - in_ready, busy, done, empty, best, best_idx and best_dist all become 0.
  - Reset mid-burst discards the partial result. No done pulse is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - in_ready = 0.
  - start = 1: latch reff and len (saturated), clear the counter and empty.
  - If len = 0, go to FIN with empty = 1 and best/best_idx/best_dist = 0.
  - Otherwise go to RUN.
- RUN:
  - in_ready = 1 and busy = 1.
  - A transfer occurs when in_valid & in_ready; no sample is taken without in_valid.
  - Distance is d = (in_data >= reff) ? in_data - reff : reff - in_data. It is exact in WIDTH bits; no sign or overflow handling is needed.
  - First transfer (counter = 0): unconditionally load best = in_data, best_idx = 0, best_dist = d.
  - Later transfers: replace best/best_idx/best_dist only if d < best_dist, strictly.
  - Ties keep the earlier sample (lower index).
  - The counter increments on each transfer.
  - On the transfer where counter = len - 1, go to FIN.
  - in_ready drops in the cycle after the last transfer, so no extra sample is consumed.
- FIN:
  - done = 1 for exactly one cycle, busy = 0, in_ready = 0.
  - Next state is IDLE.
- Result hold: best, best_idx, best_dist and empty hold their values from FIN until the next accepted start. They are not cleared when the FSM returns to IDLE.
- start outside IDLE (in RUN or FIN) is ignored and not queued.
- Latency:
  - start edge to first in_ready: 1 cycle.
  - Last transfer edge to done: 1 cycle.
  - Minimum burst duration with in_valid held high: len + 2 cycles from the start edge to the end of the done cycle.
- The best update is combinational compare plus a registered update, one comparison per cycle. There is no pipelining; the next sample compares against the already-updated best.
- in_data and in_valid are sampled only at clock edges. Changes between edges have no effect.

Test Plan:
1. reff = 100, len = 4, samples 90, 105, 97, 130 with in_valid held high -> done in cycle 6 after start; best = 97, best_idx = 2, best_dist = 3, empty = 0; exactly 4 transfers.
2. Tie: reff = 50, len = 3, samples 45, 55, 60 -> best = 45, best_idx = 0, best_dist = 5 (the later equal distance 55 does not replace it).
3. Extremes: reff = 0, len = 2, samples 255, 0 -> best = 0, idx = 1, dist = 0. Then reff = 255, samples 0, 1 -> best = 1, idx = 1, dist = 254.
4. Stalls: reff = 10, len = 3, in_valid toggled 1,0,0,1,0,1 with samples 20, 12, 9 -> only 3 transfers counted; best = 9, idx = 2, dist = 1; done one cycle after the last valid.
5. len = 0 -> done pulses 1 cycle after start; empty = 1; best/idx/dist = 0; in_ready never asserted. len = 31 -> saturates to 16 transfers.
6. Reset and ignored start:
   - start pulsed during RUN -> ignored; burst completes normally.
   - rst_n = 0 after 2 of 5 samples -> next edge gives IDLE, all outputs 0, no done.
   - A fresh burst afterwards returns a correct result.
